bitbakery_serial_tx: RTL and testbench

BITBAKERY_SERIAL_TX -- requirements
Module: bitbakery_serial_tx

---
 rtl/bitbakery_serial_tx_pkg.sv | 20 ++
 rtl/bitbakery_serial_tx_if.sv | 15 +
 rtl/bitbakery_serial_tx_uart_tx_byte.sv | 91 +++++++++
 rtl/bitbakery_serial_tx.sv | 63 ++++++
 tb/tb_bitbakery_serial_tx.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/bitbakery_serial_tx_pkg.sv
// bitbakery_serial_tx_pkg: shared timing constants, packet geometry, sequencer state encoding
//   DEF_DIV      : clock cycles per serial bit at the default clock/baud
//   DEF_GAP_BITS : idle bit periods between packets
//   PKT_LEN/W    : packet length in bytes / bits
//   state_e      : byte sequencer states (GAP doubles as the idle state)
package bitbakery_serial_tx_pkg;
    localparam int DEF_CLK_FREQ = 50_000_000;
    localparam int DEF_BAUD     = 115_200;
    localparam int DEF_DIV      = DEF_CLK_FREQ / DEF_BAUD;
    localparam int DEF_GAP_BITS = 10;
    localparam int PKT_LEN      = 11;
    localparam int PKT_W        = 8 * PKT_LEN;

    typedef enum logic [1:0] {ST_GAP, ST_START, ST_DATA, ST_STOP} state_e;

    // Byte i of the packet register, byte 0 in the least significant position.
    function automatic logic [7:0] pkt_byte(input logic [PKT_W-1:0] p, input logic [3:0] i);
        return p[{i, 3'b000} +: 8];
    endfunction
endpackage

// File: rtl/bitbakery_serial_tx_if.sv
// bitbakery_serial_tx_if: payload inputs and serial output of the packet transmitter
//   D0, D1, D2    : status, move and config bytes
//   map_obstacles : 64-bit obstacle map, sent as 8 bytes LSB byte first
//   saida_serial  : UART TX line
//   master drives the payload and watches the line; slave is the transmitter
interface bitbakery_serial_tx_if;
    logic [7:0]  D0;
    logic [7:0]  D1;
    logic [7:0]  D2;
    logic [63:0] map_obstacles;
    logic        saida_serial;

    modport master (output D0, D1, D2, map_obstacles, input saida_serial);
    modport slave  (input D0, D1, D2, map_obstacles, output saida_serial);
endinterface

// File: rtl/bitbakery_serial_tx_uart_tx_byte.sv
// uart_tx_byte: 8N1 byte transmitter with back-to-back chaining
//   clock, reset : system clock, synchronous active-high reset
//   start, data  : load data and begin a start bit (accepted when idle or on the last stop cycle)
//   busy         : a byte is in flight
//   done         : one-cycle pulse on the final cycle of the stop bit
//   tx           : registered serial line, idle high
module uart_tx_byte
    import bitbakery_serial_tx_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       tx
);
    localparam int BW = $clog2(DIV);
    localparam logic [BW-1:0] LAST = BW'(DIV - 1);

    state_e        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic          tx_q, tx_d;
    logic          last;

    always_comb begin
        last    = baud_q == LAST;
        state_d = state_q;
        baud_d  = last ? '0 : baud_q + 1'b1;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        case (state_q)
            ST_GAP: begin
                baud_d = '0;
                if (start) begin
                    state_d = ST_START;
                    sh_d    = data;
                    tx_d    = 1'b0;
                end
            end
            ST_START: if (last) begin
                state_d = ST_DATA;
                bit_d   = '0;
                tx_d    = sh_q[0];
                sh_d    = sh_q >> 1;
            end
            ST_DATA: if (last) begin
                if (bit_q == 3'd7) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end else begin
                    bit_d = bit_q + 1'b1;
                    tx_d  = sh_q[0];
                    sh_d  = sh_q >> 1;
                end
            end
            ST_STOP: if (last) begin
                // Chaining here makes the next start bit follow the stop bit with no idle cycle.
                state_d = start ? ST_START : ST_GAP;
                sh_d    = start ? data : sh_q;
                tx_d    = !start;
            end
            default: state_d = ST_GAP;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_GAP;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

    assign busy = state_q != ST_GAP;
    assign done = state_q == ST_STOP && last;
    assign tx   = tx_q;
endmodule

// File: rtl/bitbakery_serial_tx.sv
// bitbakery_serial_tx: free-running 11-byte UART packet transmitter with inter-packet gap
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : D0, D1, D2, map_obstacles in; saida_serial out
//   Packet = D0, D1, D2, map bytes [7:0] .. [63:56], then GAP_BITS idle bit periods.
module bitbakery_serial_tx
    import bitbakery_serial_tx_pkg::*;
#(
    parameter int CLK_FREQ = DEF_CLK_FREQ,
    parameter int BAUD     = DEF_BAUD,
    parameter int GAP_BITS = DEF_GAP_BITS
) (
    input  logic                   clock,
    input  logic                   reset,
    bitbakery_serial_tx_if.slave   bus
);
    localparam int DIV     = CLK_FREQ / BAUD;
    localparam int GAP_CYC = GAP_BITS * DIV;
    localparam int GW      = $clog2(GAP_CYC);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);
    localparam logic [3:0]    IDX_LAST = 4'(PKT_LEN - 1);

    logic [GW-1:0]    gap_q, gap_d;
    logic [3:0]       idx_q, idx_d;
    logic [PKT_W-1:0] pkt_q, pkt_d;
    logic             first, next, start, busy, done, tx;
    logic [7:0]       data;

    always_comb begin
        // The gap timer only runs while the byte transmitter is idle, so it also times the post-reset gap.
        first = !busy && gap_q == GAP_LAST;
        next  = done && idx_q != IDX_LAST;
        start = first || next;
        gap_d = busy ? '0 : gap_q + 1'b1;
        idx_d = first ? '0 : next ? idx_q + 4'd1 : done ? '0 : idx_q;
        pkt_d = first ? {bus.map_obstacles, bus.D2, bus.D1, bus.D0} : pkt_q;
        // Byte 0 comes straight from the inputs since the snapshot lands on the same edge.
        data  = first ? bus.D0 : pkt_byte(pkt_q, idx_q + 4'd1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            gap_q <= '0;
            idx_q <= '0;
            pkt_q <= '0;
        end else begin
            gap_q <= gap_d;
            idx_q <= idx_d;
            pkt_q <= pkt_d;
        end
    end

    uart_tx_byte #(.DIV(DIV)) u_byte (
        .clock (clock),
        .reset (reset),
        .start (start),
        .data  (data),
        .busy  (busy),
        .done  (done),
        .tx    (tx)
    );

    assign bus.saida_serial = tx;
endmodule

// File: tb/tb_bitbakery_serial_tx.sv
// tb_bitbakery_serial_tx: directed checks of packet framing, timing, snapshot and reset behaviour
module tb_bitbakery_serial_tx;
    typedef struct {
        string      name;
        logic [7:0] exp;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    vec_t vecs[11];

    bitbakery_serial_tx_if bus();

    bitbakery_serial_tx dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", nm, act, act, exp, exp);
        end
    endtask

    task automatic wait_low(output int t);
        int n = 0;
        while (bus.saida_serial !== 1'b0 && n < 20000) begin
            @(negedge clock);
            n++;
        end
        if (bus.saida_serial !== 1'b0) begin
            tests++;
            fails++;
            $display("FAIL wait_start: line still %b after %0d cycles, expected a start bit", bus.saida_serial, n);
        end
        t = cyc;
    endtask

    task automatic count_level(input logic lvl, input int init, output int n);
        n = init;
        while (n < 20000) begin
            @(negedge clock);
            if (bus.saida_serial !== lvl) break;
            n++;
        end
    endtask

    task automatic rx_bits(input int first_wait, output logic [7:0] b, output logic stp);
        repeat (first_wait) @(negedge clock);
        b[0] = bus.saida_serial;
        for (int k = 1; k < 8; k++) begin
            repeat (434) @(negedge clock);
            b[k] = bus.saida_serial;
        end
        repeat (434) @(negedge clock);
        stp = bus.saida_serial;
    endtask

    task automatic decode(output logic [7:0] b, output logic stp);
        repeat (217) @(negedge clock);
        chk("start_bit_mid", int'(bus.saida_serial), 0);
        rx_bits(434, b, stp);
    endtask

    initial begin
        int         t, t_prev, p1, n;
        logic [7:0] b;
        logic       stp;
        vecs[0]  = '{"pkt1_d0",    8'h07};
        vecs[1]  = '{"pkt1_d1",    8'h45};
        vecs[2]  = '{"pkt1_d2",    8'h9A};
        vecs[3]  = '{"pkt1_map0",  8'hEF};
        vecs[4]  = '{"pkt1_map1",  8'hCD};
        vecs[5]  = '{"pkt1_map2",  8'hAB};
        vecs[6]  = '{"pkt1_map3",  8'h89};
        vecs[7]  = '{"pkt1_map4",  8'h67};
        vecs[8]  = '{"pkt1_map5",  8'h45};
        vecs[9]  = '{"pkt1_map6",  8'h23};
        vecs[10] = '{"pkt1_map7",  8'h01};
        bus.D0 = 8'h07;
        bus.D1 = 8'h45;
        bus.D2 = 8'h9A;
        bus.map_obstacles = 64'h0123_4567_89AB_CDEF;
        n = 0;
        repeat (10) begin
            @(negedge clock);
            if (bus.saida_serial !== 1'b1) n++;
        end
        chk("reset_line_high", n, 0);
        @(posedge clock);
        #1 reset = 1'b0;
        count_level(1'b1, 0, n);
        chk("post_reset_idle", n, 4340);
        t = cyc;
        p1 = t;
        // These changes land after the packet-1 snapshot and must only show up in packet 2.
        bus.D0 = 8'h2D;
        bus.D1 = 8'h7F;
        bus.D2 = 8'h92;
        for (int i = 0; i < 11; i++) begin
            if (i > 0) begin
                wait_low(t);
                chk("byte_spacing", t - t_prev, 4340);
            end
            t_prev = t;
            decode(b, stp);
            chk(vecs[i].name, int'(b), int'(vecs[i].exp));
            chk("stop_bit", int'(stp), 1);
        end
        wait_low(t);
        chk("packet_period", t - p1, 52080);
        count_level(1'b0, 1, n);
        chk("start_bit_len", n, 434);
        rx_bits(217, b, stp);
        chk("single_byte_d0", int'(b), 'h2D);
        chk("single_byte_stop", int'(stp), 1);
        wait_low(t);
        decode(b, stp);
        chk("snapshot_new_d1", int'(b), 'h7F);
        wait_low(t);
        repeat (4 * 434 + 217) @(negedge clock);
        chk("d2_bit3_low", int'(bus.saida_serial), 0);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        bus.D0 = 8'h15;
        @(negedge clock);
        chk("mid_byte_reset_high", int'(bus.saida_serial), 1);
        count_level(1'b1, 1, n);
        chk("restart_idle", n, 4340);
        decode(b, stp);
        chk("fresh_d0", int'(b), 'h15);
        chk("fresh_stop", int'(stp), 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
